// File: rtl/wb_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Purpose : Writeback stage of the 8-bit RISC core. Selects one of NSRC
//           result sources, applies an extension/swap mode and holds the
//           result in a 2-entry skid buffer (head H, skid S) under a
//           valid/ready handshake. Provides a youngest-first forwarding
//           lookup and a wrapping 16-bit commit counter.
// Ports   : clk, rst_n (sync, active low)
//           in_valid/in_ready   upstream handshake (in_ready registered)
//           src_data, sel, mode sources, source select, result mode
//           we, waddr           write request and destination
//           out_ready           register-file port free
//           rf_we/rf_waddr/rf_wdata/out_valid  head entry to register file
//           fwd_raddr/fwd_hit/fwd_data         forwarding lookup
//           sel_err             pulse: accepted entry had sel >= NSRC
//           commit_cnt          number of completed register writes
// Revision: 1.0  initial release
// ============================================================================
module wb_stage #(
  parameter int DW      = 8,
  parameter int NSRC    = 4,
  parameter int AW      = 3,
  parameter bit ZERO_RO = 1'b1,
  parameter int SW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NSRC*DW-1:0] src_data,
  input  logic [SW-1:0]      sel,
  input  logic [1:0]         mode,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic               out_ready,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               out_valid,
  input  logic [AW-1:0]      fwd_raddr,
  output logic               fwd_hit,
  output logic [DW-1:0]      fwd_data,
  output logic               sel_err,
  output logic [15:0]        commit_cnt
);

  localparam int c_HW = DW / 2;

  localparam logic [1:0] c_MODE_PASS = 2'b00;
  localparam logic [1:0] c_MODE_ZEXT = 2'b01;
  localparam logic [1:0] c_MODE_SEXT = 2'b10;
  localparam logic [1:0] c_MODE_SWAP = 2'b11;

  // Head entry
  logic          r_h_valid;
  logic          r_h_we;
  logic [AW-1:0] r_h_addr;
  logic [DW-1:0] r_h_data;
  // Skid entry
  logic          r_s_valid;
  logic          r_s_we;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_data;

  logic          r_in_ready;
  logic          r_sel_err;
  logic [15:0]   r_commit_cnt;

  logic [DW-1:0]   w_sel_data;
  logic            w_sel_ok;
  logic [c_HW-1:0] w_lo;
  logic [c_HW-1:0] w_hi;
  logic [DW-1:0]   w_new_data;
  logic            w_new_we;
  logic            w_accept;
  logic            w_drain;
  logic            w_commit;
  logic            w_s_valid_nxt;
  logic            w_h_hit;
  logic            w_s_hit;

  // Source mux; an out-of-range select leaves the data at zero and flags it.
  always_comb begin
    w_sel_data = '0;
    w_sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SW'(k)) begin
        w_sel_data = src_data[k*DW +: DW];
        w_sel_ok   = 1'b1;
      end
    end
  end

  assign w_lo = w_sel_data[c_HW-1:0];
  assign w_hi = w_sel_data[DW-1:c_HW];

  always_comb begin
    w_new_data = w_sel_data;
    case (mode)
      c_MODE_PASS: w_new_data = w_sel_data;
      c_MODE_ZEXT: w_new_data = {{c_HW{1'b0}}, w_lo};
      c_MODE_SEXT: w_new_data = {{c_HW{w_lo[c_HW-1]}}, w_lo};
      c_MODE_SWAP: w_new_data = {w_lo, w_hi};
      default:     w_new_data = w_sel_data;
    endcase
  end

  // Register 0 is hard-wired when ZERO_RO is set, so such writes are dropped
  // at entry; this also keeps address 0 out of the forwarding match.
  assign w_new_we = we & w_sel_ok & ~(ZERO_RO & (waddr == '0));

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_h_valid & out_ready;
  assign w_commit = w_drain & r_h_we;

  // S fills only when H is stalled at accept, and empties when H drains.
  assign w_s_valid_nxt = r_s_valid ? ~w_drain : (w_accept & r_h_valid & ~w_drain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_valid    <= 1'b0;
      r_h_we       <= 1'b0;
      r_h_addr     <= '0;
      r_h_data     <= '0;
      r_s_valid    <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_addr     <= '0;
      r_s_data     <= '0;
      r_in_ready   <= 1'b0;
      r_sel_err    <= 1'b0;
      r_commit_cnt <= 16'd0;
    end else begin
      r_sel_err  <= w_accept & ~w_sel_ok;
      r_in_ready <= ~w_s_valid_nxt;
      if (w_commit) begin
        r_commit_cnt <= r_commit_cnt + 16'd1;
      end
      if (r_s_valid) begin
        // in_ready is low here, so no accept can coincide with this move.
        if (w_drain) begin
          r_h_we    <= r_s_we;
          r_h_addr  <= r_s_addr;
          r_h_data  <= r_s_data;
          r_s_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_h_valid || w_drain) begin
          r_h_valid <= 1'b1;
          r_h_we    <= w_new_we;
          r_h_addr  <= waddr;
          r_h_data  <= w_new_data;
        end else begin
          r_s_valid <= 1'b1;
          r_s_we    <= w_new_we;
          r_s_addr  <= waddr;
          r_s_data  <= w_new_data;
        end
      end else if (w_drain) begin
        r_h_valid <= 1'b0;
      end
    end
  end

  // S is always the younger entry, so it wins the forwarding lookup.
  assign w_s_hit = r_s_valid & r_s_we & (r_s_addr == fwd_raddr);
  assign w_h_hit = r_h_valid & r_h_we & (r_h_addr == fwd_raddr);

  assign fwd_hit  = w_s_hit | w_h_hit;
  assign fwd_data = w_s_hit ? r_s_data : (w_h_hit ? r_h_data : '0);

  assign in_ready   = r_in_ready;
  assign out_valid  = r_h_valid;
  assign rf_we      = w_commit;
  assign rf_waddr   = r_h_addr;
  assign rf_wdata   = r_h_data;
  assign sel_err    = r_sel_err;
  assign commit_cnt = r_commit_cnt;

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Parametrised, pipelined writeback stage for the 8-bit RISC core, sitting between the memory stage and the register-file write port. It selects one of NSRC result sources (ALU, data memory, MOV, effective address, …), applies an optional extension/swap mode, and buffers the result in a 2-entry skid buffer under a valid/ready handshake. It also exposes a youngest-first forwarding lookup and a wrapping commit counter.

## Interface
- DW, 8, data width (even, ≥4)
- NSRC, 4, number of result sources (≥2)
- AW, 3, register address width
- ZERO_RO, 1, when 1 writes to register 0 are suppressed
- SW = max(1, clog2(NSRC)), derived select width

- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept (registered)
- src_data  in  NSRC*DW  flattened sources, source k at [k*DW +: DW]
- sel  in  SW  source select
- mode  in  2  00 pass, 01 zero-extend low DW/2, 10 sign-extend low DW/2, 11 swap halves
- we  in  1  entry requests a register write
- waddr  in  AW  destination register
- out_ready  in  1  register-file port free this cycle
- rf_we  out  1  write strobe = out_valid & out_ready & head write-enable
- rf_waddr  out  AW  head destination
- rf_wdata  out  DW  head data
- out_valid  out  1  head entry present
- fwd_raddr  in  AW  forwarding lookup address
- fwd_hit  out  1  a buffered entry writes fwd_raddr
- fwd_data  out  DW  data of youngest matching entry
- sel_err  out  1  one-cycle pulse: accepted entry had sel ≥ NSRC
- commit_cnt  out  16  count of completed rf writes

## Operation
- Accept = in_valid & in_ready. Formed at accept: data = mode(src_data[sel]); effective we = we & sel<NSRC & !(ZERO_RO & waddr==0).
- sel ≥ NSRC: data forced 0, effective we 0, entry still occupies a slot, sel_err pulses the cycle after accept.
- Storage: head register H and skid register S (each valid, we, addr, data).
- Head drain = out_valid & out_ready (the entry retires whether or not it writes).
- Accept with H empty or draining, S empty: entry goes to H.
- Accept with H stalled (valid & !out_ready): entry goes to S.
- H drains while S valid: S moves to H, S cleared; a simultaneous accept is impossible (in_ready=0 whenever S is valid).
- in_ready = !S.valid, registered; 0 while rst_n low.
- Forwarding (combinational): S match (S.valid & S.we & S.addr==fwd_raddr) takes priority over H match; fwd_data = 0 when no hit. Address 0 never hits when ZERO_RO=1.
- commit_cnt increments on every rf_we, wraps 0xFFFF→0x0000.
- Reset (rst_n low at edge): H, S invalid; out_valid, rf_we, fwd_hit, sel_err = 0; rf_waddr, rf_wdata, fwd_data = 0; commit_cnt = 0; in_ready = 0. Reset mid-transfer discards both entries with no write.

## Timing
- Latency: accept at edge N → out_valid, rf_waddr, rf_wdata valid after edge N; rf_we high in cycle N+1 if out_ready.
- Throughput: 1 entry/cycle while out_ready held high; S stays empty.
- One-cycle out_ready drop: next accept lands in S, in_ready low the following cycle, returns high the cycle after S moves into H.
- in_ready rises the cycle after the first edge with rst_n high.
- rf_we, fwd_hit, fwd_data combinational from registered state and out_ready / fwd_raddr; no input-to-output path from in_* ports.
- Full: H and S valid, in_ready=0; in_valid ignored. Empty: out_valid=0, rf_we=0 regardless of out_ready.

## Test plan
- Basic select: sources 1,2,3,4, sel=2, mode=00, we=1, waddr=5, out_ready=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x03; commit_cnt=1.
- Modes: source 0x9C, sel=0 → mode 01 gives 0x0C, mode 10 gives 0xFC, mode 11 gives 0xC9.
- Backpressure: out_ready=0, accept entries A(addr 1, 0x11) and B(addr 2, 0x22) back-to-back → in_ready=0 after B; raise out_ready → A written, then B, in_ready returns 1; no loss or reorder.
- Forwarding: H=addr 3/0x33, S=addr 3/0x44, fwd_raddr=3 → fwd_hit=1, fwd_data=0x44; fwd_raddr=6 → fwd_hit=0, fwd_data=0.
- Suppression: waddr=0 with ZERO_RO=1 → entry retires, rf_we=0, commit_cnt unchanged; build with NSRC=3, sel=3 → sel_err pulse, data 0, no write.
- Reset/wrap: preload commit_cnt to 0xFFFF via 65535 writes, one more → 0x0000; assert rst_n=0 with H and S full → both cleared, no write, in_ready=0 until the cycle after release.
